// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register offsets, bit indices and state encoding for the compare/irq timer
package timer_pkg;

  localparam int unsigned REG_COUNT  = 32'h00;
  localparam int unsigned REG_CMP    = 32'h04;
  localparam int unsigned REG_CTRL   = 32'h08;
  localparam int unsigned REG_STATUS = 32'h0C;
  localparam int unsigned REG_PERIOD = 32'h10;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IRQ_EN   = 2;

  localparam int STAT_PENDING = 0;
  localparam int STAT_OVERRUN = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } state_e;

endpackage

// File: rtl/timer_match.sv
// rtl/timer_match.sv - wrap-safe comparator: hit when count is at or past cmp within half the range
module timer_match (
  input  logic [31:0] count,
  input  logic [31:0] cmp,
  input  logic        enable,
  output logic        hit
);

  logic [31:0] diff;

  assign diff = count - cmp;
  assign hit  = enable && !diff[31];

endmodule

// File: rtl/timer_compare_irq.sv
// rtl/timer_compare_irq.sv - compare/interrupt unit: register file, arm/fire FSM, periodic reload, read mux
module timer_compare_irq
  import timer_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       counter_in,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_we,
  input  logic              bus_re,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              irq
);

  state_e            state_q, state_d;
  logic [31:0]       cmp_q, cmp_d;
  logic [31:0]       period_q, period_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic [31:0]       bus_rdata_q, bus_rdata_d;

  logic [ADDR_W-1:0] addr_word;
  logic              wr_cmp, wr_ctrl, wr_status, wr_period;
  logic              armed, hit, reload;
  logic              clr_pending, clr_overrun;
  logic [31:0]       rd_mux;

  assign addr_word = bus_addr >> 2;
  assign wr_cmp    = bus_we && (addr_word == ADDR_W'(REG_CMP >> 2));
  assign wr_ctrl   = bus_we && (addr_word == ADDR_W'(REG_CTRL >> 2));
  assign wr_status = bus_we && (addr_word == ADDR_W'(REG_STATUS >> 2));
  assign wr_period = bus_we && (addr_word == ADDR_W'(REG_PERIOD >> 2));

  // Only the ARMED state may hit; FIRED and IDLE ignore the comparator.
  assign armed = (state_q == ST_ARMED) && ctrl_q[CTRL_ENABLE];

  timer_match u_match (
    .count  (counter_in),
    .cmp    (cmp_q),
    .enable (armed),
    .hit    (hit)
  );

  assign reload      = hit && ctrl_q[CTRL_PERIODIC] && (period_q != 32'd0);
  assign clr_pending = wr_status && bus_wdata[STAT_PENDING];
  assign clr_overrun = wr_status && bus_wdata[STAT_OVERRUN];

  always_comb begin
    cmp_d = cmp_q;
    if (reload) cmp_d = cmp_q + period_q;
    if (wr_cmp) cmp_d = bus_wdata;
    period_d  = wr_period ? bus_wdata : period_q;
    ctrl_d    = wr_ctrl ? bus_wdata[2:0] : ctrl_q;
    // A hit outranks a simultaneous clear, and that case is not an overrun.
    pending_d = (pending_q && !clr_pending) || hit;
    overrun_d = (overrun_q && !clr_overrun) || (hit && pending_q && !clr_pending);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARMED: if (hit && !reload) state_d = ST_FIRED;
      ST_FIRED: if (wr_cmp) state_d = ST_ARMED;
      default:  state_d = state_q;
    endcase
    if (wr_cmp && state_q == ST_ARMED) state_d = ST_ARMED;
    if (wr_ctrl) state_d = bus_wdata[CTRL_ENABLE] ? ST_ARMED : ST_IDLE;
  end

  always_comb begin
    rd_mux = 32'd0;
    case (addr_word)
      ADDR_W'(REG_COUNT >> 2):  rd_mux = counter_in;
      ADDR_W'(REG_CMP >> 2):    rd_mux = cmp_q;
      ADDR_W'(REG_CTRL >> 2):   rd_mux = {29'd0, ctrl_q};
      ADDR_W'(REG_STATUS >> 2): rd_mux = {30'd0, overrun_q, pending_q};
      ADDR_W'(REG_PERIOD >> 2): rd_mux = period_q;
      default:                  rd_mux = 32'd0;
    endcase
    bus_rdata_d = bus_re ? rd_mux : bus_rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmp_q       <= 32'd0;
      period_q    <= 32'd0;
      ctrl_q      <= 3'd0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      bus_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cmp_q       <= cmp_d;
      period_q    <= period_d;
      ctrl_q      <= ctrl_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      bus_rdata_q <= bus_rdata_d;
    end
  end

  assign bus_rdata = bus_rdata_q;
  assign irq       = pending_q && ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_timer_compare_irq.sv
// tb/tb_timer_compare_irq.sv - scoreboard bench for timer_compare_irq against a behavioural model
module tb_timer_compare_irq;

  localparam int ADDR_W  = 5;
  localparam int S_IDLE  = 0;
  localparam int S_ARMED = 1;
  localparam int S_FIRED = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       counter_in;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_we;
  logic              bus_re;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;
  logic              irq;

  always #5 clk = ~clk;

  timer_compare_irq #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .counter_in (counter_in),
    .bus_addr   (bus_addr),
    .bus_we     (bus_we),
    .bus_re     (bus_re),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .irq        (irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] rd_q[$];
  bit          irq_q[$];
  logic        re_d;

  logic [31:0] cur_cnt;
  logic [31:0] m_cmp, m_period;
  bit          m_en, m_per, m_ie, m_pend, m_ovr;
  int          m_state;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_cmp = 0; m_period = 0; m_en = 0; m_per = 0; m_ie = 0;
    m_pend = 0; m_ovr = 0; m_state = S_IDLE;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a >> 2)
      0:       return cur_cnt;
      1:       return m_cmp;
      2:       return {29'd0, m_ie, m_per, m_en};
      3:       return {30'd0, m_ovr, m_pend};
      4:       return m_period;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input logic we, input logic [4:0] a, input logic [31:0] wd);
    int unsigned idx;
    bit hit, clr_p, clr_o, was_pending;
    idx = a >> 2;
    hit = (m_state == S_ARMED) && m_en && ($signed(cur_cnt - m_cmp) >= 0);
    clr_p = we && idx == 3 && wd[0];
    clr_o = we && idx == 3 && wd[1];
    was_pending = m_pend;
    if (clr_p) m_pend = 0;
    if (clr_o) m_ovr = 0;
    if (hit) begin
      if (was_pending && !clr_p) m_ovr = 1;
      m_pend = 1;
      if (m_per && m_period != 0) m_cmp = m_cmp + m_period;
      else m_state = S_FIRED;
    end
    if (we) begin
      case (idx)
        1: begin
          m_cmp = wd;
          if (m_state != S_IDLE) m_state = S_ARMED;
        end
        2: begin
          m_en = wd[0]; m_per = wd[1]; m_ie = wd[2];
          m_state = wd[0] ? S_ARMED : S_IDLE;
        end
        4: m_period = wd;
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic we, input logic re, input logic [4:0] a, input logic [31:0] wd);
    counter_in = cur_cnt; bus_we = we; bus_re = re; bus_addr = a; bus_wdata = wd;
    if (re) rd_q.push_back(model_read(a));
    model_step(we, a, wd);
    @(posedge clk); #1;
    irq_q.push_back(m_pend && m_ie);
    bus_we = 1'b0; bus_re = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [4:0] a);
    step(1'b0, 1'b1, a, 32'd0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic read_all();
    for (int i = 0; i < 8; i++) rd(5'(i * 4));
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) re_d <= 1'b0;
    else re_d <= bus_re;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (re_d) begin
        if (rd_q.size() == 0) begin
          n_checks++;
          $display("FAIL rdata: got %h with no read outstanding", bus_rdata);
        end else begin
          check32("rdata", bus_rdata, rd_q.pop_front());
        end
      end
      if (irq_q.size() != 0) check32("irq", 32'(irq), 32'(irq_q.pop_front()));
    end
  end

  initial begin
    reset = 1'b1; counter_in = 0; bus_addr = 0; bus_we = 0; bus_re = 0; bus_wdata = 0;
    cur_cnt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check32("reset_irq", 32'(irq), 32'd0);
    check32("reset_rdata", bus_rdata, 32'd0);
    reset = 1'b0;
    read_all();

    // One-shot at 100
    cur_cnt = 95;
    wr(5'h04, 32'd100);
    wr(5'h08, 32'b101);
    for (int c = 95; c <= 105; c++) begin
      cur_cnt = 32'(c);
      idle();
    end
    rd(5'h0C); rd(5'h04);
    wr(5'h0C, 32'd1);
    idle(); idle();
    rd(5'h0C);

    // Periodic every 10, software clears after each fire
    cur_cnt = 0;
    wr(5'h08, 32'd0); wr(5'h0C, 32'd3);
    wr(5'h04, 32'd10); wr(5'h10, 32'd10); wr(5'h08, 32'b111);
    for (int c = 1; c <= 35; c++) begin
      cur_cnt = 32'(c);
      if (m_pend) wr(5'h0C, 32'd1);
      else idle();
    end
    rd(5'h04); rd(5'h0C);

    // Wrap-around compare
    wr(5'h08, 32'd0); wr(5'h0C, 32'd3);
    cur_cnt = 32'hFFFF_FFFA;
    wr(5'h04, 32'd5); wr(5'h08, 32'b101);
    for (int i = 0; i < 14; i++) begin
      cur_cnt = cur_cnt + 1;
      idle();
    end
    rd(5'h04); rd(5'h0C);

    // Periodic reload across the wrap
    wr(5'h08, 32'd0); wr(5'h0C, 32'd3);
    cur_cnt = 32'hFFFF_FFF0;
    wr(5'h04, 32'hFFFF_FFF0); wr(5'h10, 32'h20); wr(5'h08, 32'b111);
    idle();
    rd(5'h04);

    // Overrun with PERIOD=1, then clear colliding with a hit
    wr(5'h08, 32'd0); wr(5'h0C, 32'd3);
    cur_cnt = 198;
    wr(5'h10, 32'd1); wr(5'h04, 32'd200); wr(5'h08, 32'b111);
    for (int c = 199; c <= 204; c++) begin
      cur_cnt = 32'(c);
      idle();
    end
    rd(5'h0C);
    cur_cnt = 205;
    wr(5'h0C, 32'd3);
    rd(5'h0C);

    // Disable while armed: no hit, pending untouched
    wr(5'h08, 32'd0);
    cur_cnt = 295;
    wr(5'h04, 32'd300);
    for (int c = 296; c <= 305; c++) begin
      cur_cnt = 32'(c);
      idle();
    end
    rd(5'h0C); rd(5'h04); rd(5'h14); rd(5'h1C);

    // Randomised traffic
    wr(5'h08, 32'd0); wr(5'h0C, 32'd3);
    for (int i = 0; i < 600; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if ($urandom_range(0, 1) == 1) cur_cnt = cur_cnt + 1;
      case (k)
        0: wr(5'h04, cur_cnt + 32'($urandom_range(0, 12)));
        1: wr(5'h08, 32'($urandom_range(0, 7)));
        2: wr(5'h0C, 32'($urandom_range(0, 3)));
        3: wr(5'h10, 32'($urandom_range(0, 6)));
        4, 5: rd(5'($urandom_range(0, 7) * 4));
        6: wr(5'($urandom_range(5, 7) * 4), $urandom);
        default: idle();
      endcase
    end
    read_all();

    // Reset asserted mid-ARMED with irq high
    wr(5'h08, 32'd0); wr(5'h0C, 32'd3);
    cur_cnt = 1000;
    wr(5'h10, 32'd1000); wr(5'h04, 32'd1000); wr(5'h08, 32'b111);
    idle();
    check32("pre_reset_irq", 32'(irq), 32'd1);
    #2;
    irq_q.delete();
    reset = 1'b1;
    #1;
    check32("async_reset_irq", 32'(irq), 32'd0);
    check32("async_reset_rdata", bus_rdata, 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    read_all();
    idle(); idle();

    check32("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_compare_irq.md
# timer_compare_irq

Memory-mapped compare/interrupt unit that consumes the free-running 32-bit CPU timer count and raises a level interrupt to the core when the count reaches a programmed compare value. It sits on the GPIO peripheral bus beside the CPU timer, which is its only producer. The unit supports one-shot and periodic (auto-reload) modes, a sticky pending flag and overrun detection.

## Interface
- `ADDR_W`, default 5: byte-address width of the register window.
- `clk`  in  1  system clock, same clock as the CPU timer.
- `reset`  in  1  asynchronous, active-high reset.
- `counter_in`  in  32  CPU timer count; increments by at most 1 per `clk`.
- `bus_addr`  in  ADDR_W  byte address, word aligned; bits [1:0] ignored.
- `bus_we`  in  1  write strobe, single cycle.
- `bus_re`  in  1  read strobe, single cycle.
- `bus_wdata`  in  32  write data.
- `bus_rdata`  out  32  read data, registered.
- `irq`  out  1  level interrupt: `pending & CTRL.irq_en`.

## Operation
- Register map:
  - 0x00 COUNT (RO): `counter_in`.
  - 0x04 CMP (RW).
  - 0x08 CTRL (RW): bit0 `enable`, bit1 `periodic`, bit2 `irq_en`.
  - 0x0C STATUS: bit0 `pending` (W1C), bit1 `overrun` (W1C).
  - 0x10 PERIOD (RW).
  - Other addresses read 0; writes to them are ignored.
- Reset values: all registers 0, `bus_rdata` 0, `irq` 0, state IDLE.
- Wrap-safe match: `hit = enable && (counter_in - CMP)[31] == 0`, i.e. the count is at or past CMP within half the 32-bit range. Subtraction is modulo 2^32.
- FSM:
  - IDLE: while `enable`=0. Next state ARMED when `enable` is written 1.
  - ARMED: on `hit`, set `pending`.
    - If `periodic`=1 and PERIOD≠0: CMP <= CMP + PERIOD (mod 2^32) and stay in ARMED.
    - Otherwise go to FIRED.
  - FIRED: no further hits. Writing CMP, or writing CTRL with `enable`=1, returns to ARMED.
  - Any state: writing `enable`=0 goes to IDLE. `pending` and `overrun` are unchanged.
- Overrun: a `hit` while `pending` is already 1 sets `overrun`.
- Simultaneous events:
  - W1C of `pending` in the same cycle as a `hit`: `pending` stays 1 and `overrun` is not set.
  - CPU write to CMP in the same cycle as a periodic reload: the CPU write wins.
- Reads have no side effects.

## Timing
- `hit` is evaluated combinationally from `counter_in` and the current CMP.
- `pending` rises on the clock edge that ends the hit cycle. `irq` follows in the same cycle because it is a combinational AND of two flops.
- Read latency is 1 cycle: `bus_rdata` is valid the cycle after `bus_re` and holds until the next read.
- A write takes effect at the edge where `bus_we` is sampled. A hit against a new CMP can occur in the following cycle at the earliest.
- In periodic mode, the reloaded CMP is compared from the next cycle. A PERIOD of 1 therefore fires every cycle, and `overrun` sets unless software clears `pending` in time.
- `reset` asserted mid-operation clears all state immediately; `irq` drops asynchronously.

## Structure
- Shared package `timer_pkg`:
  - Register offsets.
  - CTRL/STATUS bit indices.
  - State enum {IDLE, ARMED, FIRED}.
- One sub-module, `timer_match`: combinational wrap-safe comparator with inputs `count`, `cmp`, `enable` and output `hit`. It is reusable for a future second compare channel.
- The top level contains the register file, the FSM, the reload adder and the read mux.

## Test plan
1. One-shot:
   - Stimulus: CMP=100, CTRL=0b101; drive `counter_in` 95→105.
   - Required: `pending`/`irq` rise the cycle after `counter_in`=100; no reload; state FIRED; W1C STATUS=1 drops `irq` the next cycle.
2. Periodic:
   - Stimulus: CMP=10, PERIOD=10, CTRL=0b111; software clears `pending` after each fire.
   - Required: fires at 10, 20, 30; CMP reads 40 afterwards; `overrun`=0.
3. Wrap-around:
   - Stimulus: CMP=0x0000_0005, `counter_in` from 0xFFFF_FFFA across the wrap.
   - Required: no hit before the wrap; hit when `counter_in`=5.
   - Also: periodic reload from CMP=0xFFFF_FFF0 with PERIOD=0x20 yields CMP 0x0000_0010.
4. Overrun and collision:
   - Stimulus: PERIOD=1, periodic, no clears.
   - Required: `overrun` sets on the second hit.
   - Then W1C `pending` in the same cycle as a hit: `pending` stays 1.
5. Disable, reset and bus:
   - Stimulus: CTRL=0 while ARMED.
   - Required: no hit at the match value; `pending` unchanged.
   - Reset asserted mid-ARMED: all registers 0 and `irq`=0 without waiting for `clk`.
   - Read of 0x14 returns 0 one cycle after `bus_re`.
